// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one lower-level line port between the I and D L1 caches.
// One transaction in flight at a time; a hung lower level is aborted after TIMEOUT wait cycles.
module l1_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_busy,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_busy,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_busy,
  output logic              grant_d,
  output logic              err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                mem_ren_q, mem_ren_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_busy_q, i_busy_d;
  logic                d_busy_q, d_busy_d;
  logic                grant_d_q, grant_d_d;
  logic                err_q, err_d;
  logic                last_d_q, last_d_d;
  logic                mask_vld_q, mask_vld_d;
  logic                mask_d_q, mask_d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic i_req, d_req, i_elig, d_elig, pick_d, op_wr;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_busy_q    <= 1'b1;
      d_busy_q    <= 1'b1;
      grant_d_q   <= 1'b0;
      err_q       <= 1'b0;
      last_d_q    <= 1'b0;
      mask_vld_q  <= 1'b0;
      mask_d_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_busy_q    <= i_busy_d;
      d_busy_q    <= d_busy_d;
      grant_d_q   <= grant_d_d;
      err_q       <= err_d;
      last_d_q    <= last_d_d;
      mask_vld_q  <= mask_vld_d;
      mask_d_q    <= mask_d_d;
      cnt_q       <= cnt_d;
    end
  end

  // Arbitration, transaction sequencing and completion
  always_comb begin
    state_d     = state_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_busy_d    = 1'b1;
    d_busy_d    = 1'b1;
    grant_d_d   = grant_d_q;
    err_d       = err_q;
    last_d_d    = last_d_q;
    mask_vld_d  = 1'b0;
    mask_d_d    = mask_d_q;
    cnt_d       = cnt_q;

    i_req  = i_ren | i_wen;
    d_req  = d_ren | d_wen;
    // The just-served port is masked for one cycle to absorb its registered request drop
    i_elig = i_req & ~(mask_vld_q & ~mask_d_q);
    d_elig = d_req & ~(mask_vld_q & mask_d_q);
    pick_d = d_elig & (~i_elig | ~last_d_q);
    op_wr  = pick_d ? d_wen : i_wen;

    case (state_q)
      S_IDLE: begin
        if (i_elig | d_elig) begin
          grant_d_d   = pick_d;
          mem_wen_d   = op_wr;
          mem_ren_d   = ~op_wr;
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = pick_d ? d_wdata : i_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!mem_busy) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (mem_ren_q) begin
            if (grant_d_q) d_rdata_d = mem_rdata;
            else           i_rdata_d = mem_rdata;
          end
          i_busy_d = grant_d_q;
          d_busy_d = ~grant_d_q;
          state_d  = S_DONE;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          err_d     = 1'b1;
          if (grant_d_q) d_rdata_d = '0;
          else           i_rdata_d = '0;
          i_busy_d = grant_d_q;
          d_busy_d = ~grant_d_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        last_d_d   = grant_d_q;
        mask_d_d   = grant_d_q;
        mask_vld_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_busy    = i_busy_q;
  assign d_busy    = d_busy_q;
  assign grant_d   = grant_d_q;
  assign err       = err_q;

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares one lower-level line port (RAM or L2) between the instruction L1 (I port) and the data L1 (D port).
- Each L1 side uses the same ren/wen/addr/line/busy handshake the L1 already drives downstream. The memory side speaks that same handshake.
- One transaction is outstanding at a time. Arbitration is round-robin, and a timeout reports a hung lower level.

Parameters:
- ADDR_W, 32, address width
- LINE_W, 128, cache line width
- TIMEOUT, 255, maximum WAIT cycles before abort (8-bit counter; must be 1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_ren  in  1  I-port line read request (level, held until served)
- i_wen  in  1  I-port line write request (level)
- i_addr  in  ADDR_W  I-port line address
- i_wdata  in  LINE_W  I-port write line
- i_rdata  out  LINE_W  I-port read line; valid while i_busy=0
- i_busy  out  1  0 for exactly one cycle when the I transaction completes, else 1
- d_ren, d_wen, d_addr, d_wdata, d_rdata, d_busy  same widths and meanings as the I-port signals, for the D port
- mem_ren  out  1  lower-level read strobe (level)
- mem_wen  out  1  lower-level write strobe (level)
- mem_addr  out  ADDR_W  lower-level address
- mem_wdata  out  LINE_W  lower-level write line
- mem_rdata  in  LINE_W  lower-level read line; sampled when mem_busy=0 in WAIT
- mem_busy  in  1  lower-level busy; 0 means done
- grant_d  out  1  1 = current/last grant to D, 0 = I
- err  out  1  sticky timeout flag

Behaviour:
- Reset values: state=IDLE; mem_ren=mem_wen=0; mem_addr=mem_wdata=0; i_busy=d_busy=1; i_rdata=d_rdata=0; grant_d=0; err=0; last-served=I; mask=none; timeout counter=0.
- All outputs are registered. A reset asserted in any state returns to the reset values on the next edge; any in-flight lower-level transaction is abandoned.
- A port requests when ren|wen. If both ren and wen are high on a port, wen wins (write performed, no read data returned).
- IDLE:
  - Eligible ports are the requesting ports minus the masked port.
  - If only one port is eligible, grant it. If both are eligible, grant the port not last served (round-robin). If none, stay in IDLE.
  - On grant: latch port, op, addr and wdata; drive mem_ren or mem_wen, mem_addr and mem_wdata; set grant_d; go to ISSUE.
- ISSUE: hold the strobes. mem_busy is ignored (the lower level needs one cycle to raise it). Go to WAIT; clear the timeout counter.
- WAIT:
  - Hold the strobes and count up each cycle.
  - If mem_busy=0: drop the strobes. On a read, copy mem_rdata into the granted port's rdata (the other port's rdata is unchanged). Go to DONE.
  - Else if the counter reaches TIMEOUT: drop the strobes, set err=1, load the granted port's rdata with 0, go to DONE.
- DONE:
  - The granted port's busy=0 for this one cycle; the other port's busy stays 1.
  - Set last-served=granted, set mask=granted for the next cycle, go to IDLE.
- Mask: valid only in the first IDLE cycle after DONE. This absorbs the requester's registered ren/wen drop. It is cleared afterwards.
- Latency, uncontended read: request seen at edge N -> mem_ren high from N+1; earliest mem_busy=0 sampled at N+3 -> busy=0 during the cycle after N+3, with rdata valid in that same cycle.
- Busy semantics: a port never sees busy=0 without a completed (or aborted) transaction of its own.
- Request inputs are not re-sampled after grant. addr/wdata changes after grant are ignored.
- err clears only on reset. The arbiter keeps serving requests after a timeout.

Test Plan:
- I read alone, addr 0x0000_1230, lower level returns line 0x0123..EF after 2 busy cycles -> mem_ren with mem_addr 0x1230; i_rdata=0x0123..EF while i_busy=0 (one cycle); d_busy stays 1; grant_d=0.
- I and D both request in the same cycle after reset -> D served first (last-served=I), I next; mem strobes never overlap; grant_d sequence 1 then 0.
- D write (wen) of line 0xAAAA..55 to 0x0000_4000 with I ren held continuously -> mem_wen with data 0xAAAA..55; d_rdata unchanged; I then served; D not re-granted in the masked cycle.
- D holds ren|wen high for two cycles after its DONE with I idle -> no second D transaction in the masked cycle; a second transaction starts only if the request is still held in the cycle after.
- TIMEOUT=4, lower level holds mem_busy=1 -> abort after 4 WAIT cycles; err=1; granted rdata=0 with busy=0 for one cycle; the next request is still served normally with err staying 1.
- Reset asserted in WAIT -> next edge: mem_ren=0, both busy=1, state IDLE, err=0.
